// File: rtl/crush_pkg.sv
// crush_pkg: shared RV32I load/store encodings and LSU state type for the crush CPU
package crush_pkg;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    localparam logic [2:0] FUNCT3_LB  = 3'd0;
    localparam logic [2:0] FUNCT3_LH  = 3'd1;
    localparam logic [2:0] FUNCT3_LW  = 3'd2;
    localparam logic [2:0] FUNCT3_LBU = 3'd4;
    localparam logic [2:0] FUNCT3_LHU = 3'd5;
    localparam logic [2:0] FUNCT3_SB  = 3'd0;
    localparam logic [2:0] FUNCT3_SH  = 3'd1;
    localparam logic [2:0] FUNCT3_SW  = 3'd2;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_BUS,
        LSU_BACKOFF,
        LSU_RESP
    } lsu_state_t;

    function automatic logic funct3_ok(input logic we, input logic [2:0] f3);
        return we ? (f3 <= FUNCT3_SW) : (f3 != 3'd3 && f3 <= FUNCT3_LHU);
    endfunction

endpackage

// File: rtl/lsu_wishbone_if.sv
// lsu_wishbone_if: execute-side request/response plus Wishbone data bus of the LSU
interface lsu_wishbone_if;

    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] adr_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;
    logic        rty_i;

    modport master (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        input  dat_i, ack_i, err_i, rty_i
    );

    modport slave (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        output dat_i, ack_i, err_i, rty_i
    );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: store lane steering (sel/dat) and load lane extract with sign/zero extension
module lsu_align
    import crush_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_addr_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        sel_o = st_funct3_i[1:0] == 2'd0 ? 4'b0001 << st_addr_i :
                st_funct3_i[1:0] == 2'd1 ? 4'b0011 << {st_addr_i[1], 1'b0} : 4'hF;
        dat_o = st_funct3_i[1:0] == 2'd0 ? {4{st_wdata_i[7:0]}} :
                st_funct3_i[1:0] == 2'd1 ? {2{st_wdata_i[15:0]}} : st_wdata_i;
        byte_v = 8'(ld_word_i >> {ld_addr_i, 3'b000});
        half_v = 16'(ld_word_i >> {ld_addr_i[1], 4'b0000});
        // funct3[2] set selects the unsigned (LBU/LHU) variant
        ld_data_o = ld_funct3_i[1:0] == 2'd0 ? {{24{~ld_funct3_i[2] & byte_v[7]}}, byte_v} :
                    ld_funct3_i[1:0] == 2'd1 ? {{16{~ld_funct3_i[2] & half_v[15]}}, half_v} : ld_word_i;
    end

endmodule

// File: rtl/lsu_wishbone.sv
// lsu_wishbone: data-side load/store unit running one Wishbone classic cycle per request; LSU_MISALIGN_TRAP_EN traps misaligned half/word
module lsu_wishbone
    import crush_pkg::*;
#(
    parameter int MAX_RETRY      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic            clk_i,
    input logic            rst_ni,
    lsu_wishbone_if.master bus
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    lsu_state_t  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] adr_q, adr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [3:0]  sel_s;
    logic [31:0] dat_s;
    logic [31:0] ld_data;
    logic        bad_req;

    lsu_align u_align (
        .st_funct3_i(bus.req_funct3_i),
        .st_addr_i  (bus.req_addr_i[1:0]),
        .st_wdata_i (bus.req_wdata_i),
        .sel_o      (sel_s),
        .dat_o      (dat_s),
        .ld_funct3_i(funct3_q),
        .ld_addr_i  (addr_lo_q),
        .ld_word_i  (bus.dat_i),
        .ld_data_o  (ld_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign bad_req = !funct3_ok(bus.req_we_i, bus.req_funct3_i) ||
                     (bus.req_funct3_i[1:0] == 2'd1 && bus.req_addr_i[0]) ||
                     (bus.req_funct3_i[1:0] == 2'd2 && bus.req_addr_i[1:0] != 2'd0);
`else
    assign bad_req = !funct3_ok(bus.req_we_i, bus.req_funct3_i);
`endif

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        adr_d     = adr_q;
        sel_d     = sel_q;
        dat_d     = dat_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        retry_d   = retry_q;
        tmo_d     = tmo_q;
        unique case (state_q)
            LSU_IDLE: if (bus.req_valid_i) begin
                we_d      = bus.req_we_i;
                funct3_d  = bus.req_funct3_i;
                addr_lo_d = bus.req_addr_i[1:0];
                adr_d     = {bus.req_addr_i[31:2], 2'b00};
                sel_d     = sel_s;
                dat_d     = dat_s;
                rdata_d   = '0;
                err_d     = bad_req;
                retry_d   = '0;
                tmo_d     = '0;
                state_d   = bad_req ? LSU_RESP : LSU_BUS;
            end
            LSU_BUS: begin
                tmo_d = tmo_q + 1'b1;
                // err beats ack beats rty when several terminations coincide
                if (bus.err_i) begin
                    err_d   = 1'b1;
                    state_d = LSU_RESP;
                end else if (bus.ack_i) begin
                    rdata_d = we_q ? '0 : ld_data;
                    state_d = LSU_RESP;
                end else if (bus.rty_i) begin
                    err_d   = retry_q == RW'(MAX_RETRY);
                    retry_d = retry_q + 1'b1;
                    state_d = retry_q == RW'(MAX_RETRY) ? LSU_RESP : LSU_BACKOFF;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = LSU_RESP;
                end
            end
            LSU_BACKOFF: begin
                tmo_d   = '0;
                state_d = LSU_BUS;
            end
            LSU_RESP: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= LSU_IDLE;
            we_q      <= 1'b0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            adr_q     <= '0;
            sel_q     <= '0;
            dat_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            retry_q   <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            adr_q     <= adr_d;
            sel_q     <= sel_d;
            dat_q     <= dat_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            retry_q   <= retry_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus.req_ready_o = state_q == LSU_IDLE;
    assign bus.rsp_valid_o = state_q == LSU_RESP;
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;
    assign bus.cyc_o       = state_q == LSU_BUS;
    assign bus.stb_o       = state_q == LSU_BUS;
    assign bus.we_o        = we_q;
    assign bus.adr_o       = adr_q;
    assign bus.sel_o       = sel_q;
    assign bus.dat_o       = dat_q;

endmodule

// File: tb/tb_lsu_wishbone.sv
// tb_lsu_wishbone: directed plus randomized accesses checked against a byte-level reference model
module tb_lsu_wishbone;

    localparam int MAXR = 4;
    localparam int TMO  = 256;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    lsu_wishbone_if bus ();

    lsu_wishbone #(.MAX_RETRY(MAXR), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int m_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
        int nb = m_bytes(f3);
        return nb == 4 ? 0 : int'(a % 4) / nb * nb;
    endfunction

    function automatic logic m_bad(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int nb;
        if (we ? f3 > 3'd2 : (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
        nb = m_bytes(f3);
        return TRAP && (a % nb) != 0;
    endfunction

    function automatic logic [3:0] m_sel(input logic [2:0] f3, input logic [31:0] a);
        int nb = m_bytes(f3);
        return 4'(((1 << nb) - 1) << m_off(f3, a));
    endfunction

    function automatic logic [31:0] m_dat(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        int nb = m_bytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(w >> (8 * (i % nb)));
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int    nb = m_bytes(f3);
        longint v = longint'((w >> (8 * m_off(f3, a)))) & ((64'h1 << (8 * nb)) - 1);
        if (!f3[2] && nb < 4 && v >= longint'(64'h1 << (8 * nb - 1))) v = v - longint'(64'h1 << (8 * nb));
        return v[31:0];
    endfunction

    // term: 0 ack, 1 err, 2 err+ack, 3 silent (timeout), 4 ack+rty; n_rty rty replies precede it
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] word, input int n_rty, input int term);
        int k = 1, phases = 0, rl = n_rty, r, e_lat, e_ph;
        logic prev = 1'b0, unstable = 1'b0, got = 1'b0, bad, e_err;
        logic [3:0] s0 = '0;
        logic [31:0] a0 = '0, d0 = '0, rd = '0, e_rd;
        logic w0 = 1'b0, re = 1'b0;
        bad   = m_bad(we, f3, addr);
        r     = n_rty > MAXR + 1 ? MAXR + 1 : n_rty;
        e_err = bad || r > MAXR || term == 1 || term == 2 || term == 3;
        e_ph  = bad ? 0 : r > MAXR ? r : r + 1;
        e_lat = bad ? 1 : r > MAXR ? 2 * r : 2 * r + 1 + (term == 3 ? TMO : 1);
        e_rd  = (e_err || we) ? 32'h0 : m_load(f3, addr, word);
        @(negedge clk);
        chk("ready_idle", bus.req_ready_o, 1);
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = we;
        bus.req_funct3_i = f3;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        @(posedge clk);
        #1;
        bus.req_valid_i  = 1'b0;
        bus.req_wdata_i  = $urandom;
        bus.req_addr_i   = $urandom;
        while (k < 600) begin
            if (bus.rsp_valid_o) begin
                got = 1'b1;
                rd  = bus.rsp_rdata_o;
                re  = bus.rsp_err_o;
                break;
            end
            if (bus.stb_o) begin
                if (phases == 0) begin
                    s0 = bus.sel_o; a0 = bus.adr_o; d0 = bus.dat_o; w0 = bus.we_o;
                end else if ({bus.sel_o, bus.adr_o, bus.dat_o, bus.we_o} !== {s0, a0, d0, w0}) unstable = 1'b1;
                if (!prev) phases++;
                if (rl > 0) begin
                    bus.rty_i = 1'b1;
                    rl--;
                end else begin
                    bus.err_i = term == 1 || term == 2;
                    bus.ack_i = term == 0 || term == 2 || term == 4;
                    bus.rty_i = term == 4;
                end
            end
            bus.dat_i = bus.ack_i ? word : $urandom;
            prev = bus.stb_o;
            @(posedge clk);
            #1;
            bus.ack_i = 1'b0;
            bus.err_i = 1'b0;
            bus.rty_i = 1'b0;
            k++;
        end
        chk("rsp_seen", 32'(got), 1);
        chk("latency", k, e_lat);
        chk("rsp_err", 32'(re), 32'(e_err));
        chk("rsp_rdata", rd, e_rd);
        chk("stb_phases", phases, e_ph);
        if (phases > 0) begin
            chk("sel", 32'(s0), 32'(m_sel(f3, addr)));
            chk("adr", a0, {addr[31:2], 2'b00});
            chk("we", 32'(w0), 32'(we));
            chk("bus_stable", 32'(unstable), 0);
            if (we) chk("dat_o", d0, m_dat(f3, wdata));
        end
        @(posedge clk);
        #1;
        chk("rsp_one_cycle", 32'(bus.rsp_valid_o), 0);
        chk("ready_after", 32'(bus.req_ready_o), 1);
    endtask

    initial begin
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = '0;
        bus.req_addr_i   = '0;
        bus.req_wdata_i  = '0;
        bus.dat_i        = '0;
        bus.ack_i        = 1'b0;
        bus.err_i        = 1'b0;
        bus.rty_i        = 1'b0;
        #2;
        chk("rst_ready", 32'(bus.req_ready_o), 1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
        chk("rst_rdata", bus.rsp_rdata_o, 0);
        chk("rst_err", 32'(bus.rsp_err_o), 0);
        chk("rst_cyc_stb_we", {29'h0, bus.cyc_o, bus.stb_o, bus.we_o}, 0);
        chk("rst_adr", bus.adr_o, 0);
        chk("rst_sel", 32'(bus.sel_o), 0);
        chk("rst_dat", bus.dat_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        access(1'b0, 3'd2, 32'h2000_0000, 32'h0, 32'h0000_0001, 0, 0);
        access(1'b0, 3'd0, 32'h2000_0003, 32'h0, 32'h0302_0180, 0, 0);
        access(1'b0, 3'd0, 32'h2000_0000, 32'h0, 32'h0302_0180, 0, 0);
        access(1'b0, 3'd1, 32'h2000_0002, 32'h0, 32'h8382_8180, 0, 0);
        access(1'b0, 3'd5, 32'h2000_0002, 32'h0, 32'h8382_8180, 0, 0);
        access(1'b1, 3'd0, 32'h2000_0001, 32'h0000_00AB, 32'h1234_5678, 0, 0);
        access(1'b1, 3'd1, 32'h2000_0006, 32'hDEAD_BEEF, 32'h0, 0, 0);
        access(1'b0, 3'd2, 32'h2000_0000, 32'h0, 32'h5555_AAAA, MAXR + 1, 0);
        access(1'b0, 3'd2, 32'h2000_0000, 32'h0, 32'h5555_AAAA, MAXR, 0);
        access(1'b0, 3'd4, 32'h2000_0001, 32'h0, 32'h0000_F000, 2, 0);
        access(1'b0, 3'd2, 32'h2000_0004, 32'h0, 32'h1111_2222, 0, 2);
        access(1'b0, 3'd2, 32'h2000_0004, 32'h0, 32'h1111_2222, 0, 4);
        access(1'b1, 3'd2, 32'h2000_0008, 32'hCAFE_F00D, 32'h0, 0, 1);
        access(1'b0, 3'd2, 32'h2000_0002, 32'h0, 32'h89AB_CDEF, 0, 0);
        access(1'b0, 3'd1, 32'h2000_0001, 32'h0, 32'h89AB_CDEF, 0, 0);
        access(1'b0, 3'd3, 32'h2000_0000, 32'h0, 32'h0, 0, 0);
        access(1'b1, 3'd4, 32'h2000_0000, 32'h0, 32'h0, 0, 0);
        access(1'b0, 3'd2, 32'h2000_0010, 32'h0, 32'h0, 0, 3);

        // reset while the bus cycle is open must drop cyc/stb and produce no response
        @(negedge clk);
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = 3'd2;
        bus.req_addr_i   = 32'h2000_0020;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        chk("midrst_cyc_before", 32'(bus.cyc_o), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_cyc_stb", {30'h0, bus.cyc_o, bus.stb_o}, 0);
        chk("midrst_ready", 32'(bus.req_ready_o), 1);
        @(posedge clk);
        #1;
        chk("midrst_no_rsp", 32'(bus.rsp_valid_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_no_rsp_after", 32'(bus.rsp_valid_o), 0);

        for (int i = 0; i < 40; i++) begin
            logic we;
            logic [2:0] f3;
            int pick, term, n_rty;
            we    = 1'($urandom_range(0, 1));
            f3    = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            pick  = $urandom_range(0, 5);
            term  = pick < 3 ? 0 : pick == 3 ? 1 : pick == 4 ? 2 : 4;
            n_rty = $urandom_range(0, 3) == 0 ? $urandom_range(1, MAXR + 1) : 0;
            access(we, f3, 32'h2000_0000 | ($urandom & 32'h0000_FFFF), $urandom, $urandom, n_rty, term);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
